dma_xfer_timing_ctrl: RTL

//  Parametrised transfer-timing controller for the DMA engine.
//  - Arbitrates NUM_CH request lines (fixed or rotating priority) and runs the SI/S0..S4 bus-cycle FSM.
//  - Supports demand, single, block and verify transfers, compressed timing, extended write, TC and external EOP.
//  - Sits between the host bus handshake (HRQ/HLDA) and the address/count datapath, which it steps via upd_pulse.

---
 rtl/dma_xfer_timing_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dma_xfer_timing_ctrl.sv
// DMA transfer-timing controller: request arbitration plus the SI/S0..S4 bus-cycle FSM.
// Drives host hold handshake, per-channel acknowledge, bus strobes and the datapath step pulse.
module dma_xfer_timing_ctrl #(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_CH-1:0]     dreq,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [2*NUM_CH-1:0]   xfer_mode,
    input  logic [2*NUM_CH-1:0]   xfer_dir,
    input  logic                  rot_prio,
    input  logic                  compressed,
    input  logic                  ext_write,
    input  logic                  cs_n,
    input  logic                  hlda,
    input  logic                  eop_n_in,
    input  logic                  cnt_is_zero,
    input  logic                  addr_lo_wrap,
    input  logic                  status_rd,
    output logic                  hrq,
    output logic                  aen,
    output logic                  adstb,
    output logic [NUM_CH-1:0]     dack,
    output logic                  ior_n,
    output logic                  iow_n,
    output logic                  memr_n,
    output logic                  memw_n,
    output logic                  eop_n_out,
    output logic [CH_W-1:0]       active_ch,
    output logic                  upd_pulse,
    output logic [NUM_CH-1:0]     tc_status
);

    localparam logic [2:0] ST_SI = 3'd0;
    localparam logic [2:0] ST_S0 = 3'd1;
    localparam logic [2:0] ST_S1 = 3'd2;
    localparam logic [2:0] ST_S2 = 3'd3;
    localparam logic [2:0] ST_S3 = 3'd4;
    localparam logic [2:0] ST_S4 = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic [CH_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic              eop_pend_q, eop_pend_d;
    logic [NUM_CH-1:0] tc_q, tc_d;

    logic [NUM_CH-1:0] valid;
    logic [1:0]        cur_mode, cur_dir;
    logic              is_read, is_write, in_xfer, term;
    logic              win_found;
    logic [CH_W-1:0]   win_ch;
    logic [2:0]        block_next;
    int unsigned       idx;

    assign valid    = dreq & ~ch_mask;
    assign cur_mode = xfer_mode[{active_ch_q, 1'b0} +: 2];
    assign cur_dir  = xfer_dir[{active_ch_q, 1'b0} +: 2];
    assign is_read  = (cur_dir == 2'b10);
    assign is_write = (cur_dir == 2'b01);
    assign in_xfer  = (state_q == ST_S1) || (state_q == ST_S2) ||
                      (state_q == ST_S3) || (state_q == ST_S4);
    assign term     = cnt_is_zero | eop_pend_q | ~eop_n_in;
    assign block_next = (compressed && !addr_lo_wrap) ? ST_S2 : ST_S1;

    // Scan starts at the rotating pointer, or at ch0 for fixed priority.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = i + (rot_prio ? 32'(prio_ptr_q) : 32'd0);
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!win_found && valid[CH_W'(idx)]) begin
                win_found = 1'b1;
                win_ch    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        prio_ptr_d  = prio_ptr_q;
        eop_pend_d  = eop_pend_q;
        tc_d        = status_rd ? '0 : tc_q;
        case (state_q)
            ST_SI: begin
                if (win_found && cs_n) begin
                    active_ch_d = win_ch;
                    state_d     = ST_S0;
                end
            end
            ST_S0: begin
                if (hlda)                     state_d = ST_S1;
                else if (!dreq[active_ch_q])  state_d = ST_SI;
            end
            ST_S1: state_d = hlda ? ST_S2 : ST_SI;
            ST_S2: state_d = !hlda ? ST_SI : (compressed ? ST_S4 : ST_S3);
            ST_S3: state_d = hlda ? ST_S4 : ST_SI;
            ST_S4: begin
                if (!hlda) begin
                    state_d = ST_SI;
                end else if (term) begin
                    tc_d[active_ch_q] = 1'b1;
                    state_d           = ST_SI;
                end else if (cur_mode == 2'b10) begin
                    state_d = block_next;
                end else if (cur_mode == 2'b00) begin
                    state_d = valid[active_ch_q] ? block_next : ST_SI;
                end else begin
                    state_d = ST_SI;
                end
            end
            default: state_d = ST_SI;
        endcase

        if ((state_q == ST_S1 || state_q == ST_S2 || state_q == ST_S3) && !eop_n_in)
            eop_pend_d = 1'b1;
        if (state_d == ST_SI)
            eop_pend_d = 1'b0;
        if (state_d == ST_SI && state_q != ST_SI && rot_prio)
            prio_ptr_d = (active_ch_q == CH_W'(NUM_CH - 1)) ? '0 : active_ch_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_SI;
            active_ch_q <= '0;
            prio_ptr_q  <= '0;
            eop_pend_q  <= 1'b0;
            tc_q        <= '0;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            prio_ptr_q  <= prio_ptr_d;
            eop_pend_q  <= eop_pend_d;
            tc_q        <= tc_d;
        end
    end

    logic rd_phase, wr_phase;
    assign rd_phase = (state_q == ST_S2) || (state_q == ST_S3) || (state_q == ST_S4);
    assign wr_phase = (state_q == ST_S3) || (state_q == ST_S4) || ((state_q == ST_S2) && ext_write);

    always_comb begin
        dack = '0;
        if (in_xfer) dack[active_ch_q] = 1'b1;
    end

    assign hrq       = (state_q != ST_SI);
    assign aen       = in_xfer;
    assign adstb     = (state_q == ST_S1);
    assign memr_n    = ~(rd_phase & is_read);
    assign ior_n     = ~(rd_phase & is_write);
    assign iow_n     = ~(wr_phase & is_read);
    assign memw_n    = ~(wr_phase & is_write);
    // A cycle aborted by hold loss or reset must not step the datapath.
    assign upd_pulse = (state_q == ST_S4) & hlda & ~RESET;
    assign eop_n_out = ~((state_q == ST_S4) & cnt_is_zero & hlda & ~RESET);
    assign active_ch = active_ch_q;
    assign tc_status = tc_q;

endmodule
